alu_ram_sequencer: RTL and testbench
====================================

Name: alu_ram_sequencer

Overview:
- Command-driven initiator for the register-file/ALU datapath (TOP). It drives data, write_enable, addr_write, addr0, addr1 and select, and samples result, zero_flag and carry_flag.
- Accepts load and execute commands over a valid/ready handshake, optionally writes the ALU result back to the register file, and returns result and flags over a valid/ready response channel.
- Replaces hand-sequenced stimulus as the datapath's controller.

Parameters:
- SETTLE_CYCLES, 2, cycles addr0/addr1/select are held before result/flags are sampled; legal range 1..15.
- CNT_W, 16, width of completed-command counter.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept command
- cmd_op  input  2  0=LOAD, 1=EXEC, 2=EXEC_WB, 3=illegal
- cmd_imm  input  8  LOAD immediate
- cmd_dst  input  4  write address (LOAD, EXEC_WB)
- cmd_src0  input  4  ALU operand A address
- cmd_src1  input  4  ALU operand B address
- cmd_sel  input  3  ALU operation select
- data  output  8  register-file write data to TOP
- write_enable  output  1  register-file write strobe to TOP
- addr_write  output  4  register-file write address to TOP
- addr0  output  4  read address A to TOP
- addr1  output  4  read address B to TOP
- select  output  3  ALU select to TOP
- result  input  8  ALU result from TOP
- zero_flag  input  1  ALU zero flag from TOP
- carry_flag  input  1  ALU carry flag from TOP
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_result  output  8  captured result / immediate
- rsp_zero  output  1  captured zero flag
- rsp_carry  output  1  captured carry flag
- rsp_err  output  1  illegal command
- cmd_count  output  CNT_W  completed responses, wraps

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- While reset is high at a rising edge:
  - state goes to IDLE.
  - All outputs go to 0, including cmd_ready; cmd_count is cleared.
  - Any in-flight command is abandoned: no write, no response.
- TOP-facing outputs and response outputs come only from registers and state. There is no combinational path from cmd_* or rsp_ready to any output.
- TOP read path (addr/select to result/flags) is combinational. The register-file write occurs at the rising edge where write_enable=1.

States:
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch all cmd_* fields.
  - op0 -> LOAD; op1/op2 -> EXEC with settle counter = SETTLE_CYCLES-1; op3 -> RESP with rsp_err=1 and rsp_result=0.
- LOAD (1 cycle):
  - write_enable=1, data=imm, addr_write=dst.
  - Capture rsp_result=imm, rsp_zero=(imm==0), rsp_carry=0; -> RESP.
- EXEC (SETTLE_CYCLES cycles):
  - addr0=src0, addr1=src1, select=sel, updated on entry.
  - Counter decrements each cycle. In the cycle where counter==0, capture result/zero_flag/carry_flag.
  - -> WB if op2, else RESP.
- WB (1 cycle):
  - write_enable=1, data=captured result, addr_write=dst; -> RESP.
  - addr0/addr1/select stay held.
- RESP:
  - rsp_valid=1; rsp_* stable until rsp_ready=1.
  - On handshake: cmd_count+1 (wraps to 0 at max), -> IDLE.
  - cmd_ready=0.

Output rules:
- write_enable is 1 only in LOAD and WB, for exactly one cycle per command.
- data, addr_write, addr0, addr1 and select hold their last values outside the states that drive them.
- cmd_ready is 0 in every state except IDLE, so no command overlaps another.

Latency:
- Accept edge = T. rsp_valid first rises on:
  - LOAD: T+2.
  - EXEC: T+1+SETTLE_CYCLES.
  - EXEC_WB: T+2+SETTLE_CYCLES.
  - Illegal: T+1.
- Back-to-back: a new command is accepted in the cycle after the response handshake (IDLE cycle).

Boundary conditions:
- EXEC_WB with dst equal to src0 or src1: operands are sampled before the write, so the result uses old values.
- rsp_ready held low: the sequencer stalls in RESP indefinitely, with no TOP writes.
- Reset during WB: the write is suppressed from the next edge; the register-file contents are not rolled back.
- SETTLE_CYCLES=1: EXEC lasts exactly one cycle.

Test Plan:
- LOAD 100->r1, 50->r2, 150->r3, 250->r4, rsp_ready=1 -> write_enable single-cycle pulses with matching data/addr_write; rsp_result 100, 50, 150, 250; cmd_count=4.
- After the loads, EXEC src0=4 src1=2 sel=0 (add) -> rsp_result=44, rsp_carry=1, rsp_zero=0; rsp_valid at T+3 with SETTLE_CYCLES=2; no write_enable pulse.
- EXEC_WB src0=4 src1=2 sel=1 (sub) dst=5, then EXEC src0=5 src1=5 sel=1 -> first rsp_result=200 with one write of 200 to r5; second rsp_result=0, rsp_zero=1.
- Illegal op=3 -> rsp_err=1, rsp_result=0 at T+1, no write_enable; next LOAD has rsp_err=0.
- Hold rsp_ready=0 for 20 cycles after an EXEC -> rsp_valid and rsp_* stable, cmd_ready=0, cmd_valid ignored; release -> single handshake, cmd_count+1.
- Assert reset in the WB cycle of EXEC_WB dst=6 -> next cycle write_enable=0, rsp_valid never rises, cmd_count=0, cmd_ready=1 one cycle after reset deasserts.

Source files
------------

// File: rtl/alu_ram_sequencer.sv
// Command sequencer for the register-file/ALU datapath: runs LOAD / EXEC / EXEC_WB
// commands against TOP and returns the result and flags over a valid/ready channel.
module alu_ram_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_imm,
  input  logic [3:0]       cmd_dst,
  input  logic [3:0]       cmd_src0,
  input  logic [3:0]       cmd_src1,
  input  logic [2:0]       cmd_sel,
  output logic [7:0]       data,
  output logic             write_enable,
  output logic [3:0]       addr_write,
  output logic [3:0]       addr0,
  output logic [3:0]       addr1,
  output logic [2:0]       select,
  input  logic [7:0]       result,
  input  logic             zero_flag,
  input  logic             carry_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [CNT_W-1:0] cmd_count
);

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, WB, RESP} state_t;

  // Only the fields needed after the accept cycle are kept; operand
  // addresses and select go straight into their output registers.
  typedef struct packed {
    logic [1:0] op;
    logic [7:0] imm;
    logic [3:0] dst;
  } cmd_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state, nxt;
  cmd_t       cmd_q;
  logic [3:0] settle;
  logic       accept;
  logic       rsp_fire;

  always_comb begin
    nxt      = state;
    accept   = (state == IDLE) && cmd_valid && cmd_ready;
    rsp_fire = (state == RESP) && rsp_ready;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            2'd0:    nxt = LOAD;
            2'd3:    nxt = RESP;
            default: nxt = EXEC;
          endcase
        end
      end
      LOAD:    nxt = RESP;
      EXEC: begin
        if (settle == 4'd0) nxt = (cmd_q.op == 2'd2) ? WB : RESP;
      end
      WB:      nxt = RESP;
      RESP: begin
        if (rsp_fire) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cmd_q        <= '0;
      settle       <= '0;
      cmd_ready    <= 1'b0;
      data         <= '0;
      write_enable <= 1'b0;
      addr_write   <= '0;
      addr0        <= '0;
      addr1        <= '0;
      select       <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_err      <= 1'b0;
      cmd_count    <= '0;
    end else begin
      state        <= nxt;
      // Every output is a register, so these track the state being entered.
      cmd_ready    <= (nxt == IDLE);
      write_enable <= (nxt == LOAD) || (nxt == WB);
      rsp_valid    <= (nxt == RESP);

      case (state)
        IDLE: begin
          if (accept) begin
            cmd_q   <= '{op: cmd_op, imm: cmd_imm, dst: cmd_dst};
            rsp_err <= 1'b0;
            case (cmd_op)
              2'd0: begin
                data       <= cmd_imm;
                addr_write <= cmd_dst;
              end
              2'd3: begin
                rsp_err    <= 1'b1;
                rsp_result <= '0;
                rsp_zero   <= 1'b0;
                rsp_carry  <= 1'b0;
              end
              default: begin
                addr0  <= cmd_src0;
                addr1  <= cmd_src1;
                select <= cmd_sel;
                settle <= SETTLE_INIT;
              end
            endcase
          end
        end
        LOAD: begin
          rsp_result <= cmd_q.imm;
          rsp_zero   <= (cmd_q.imm == 8'd0);
          rsp_carry  <= 1'b0;
        end
        EXEC: begin
          if (settle == 4'd0) begin
            rsp_result <= result;
            rsp_zero   <= zero_flag;
            rsp_carry  <= carry_flag;
            // Write-back data is staged here so WB drives it for one cycle.
            if (cmd_q.op == 2'd2) begin
              data       <= result;
              addr_write <= cmd_q.dst;
            end
          end else begin
            settle <= settle - 4'd1;
          end
        end
        RESP: begin
          if (rsp_fire) cmd_count <= cmd_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ram_sequencer.sv
// Bench for alu_ram_sequencer: behavioural register file/ALU stands in for TOP, a
// shadow register array predicts responses, latencies and write-backs.
module tb_alu_ram_sequencer;

  localparam int S = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_imm;
  logic [3:0]  cmd_dst, cmd_src0, cmd_src1;
  logic [2:0]  cmd_sel;
  logic [7:0]  data;
  logic        write_enable;
  logic [3:0]  addr_write, addr0, addr1;
  logic [2:0]  select;
  logic [7:0]  result;
  logic        zero_flag, carry_flag;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_result;
  logic        rsp_zero, rsp_carry, rsp_err;
  logic [15:0] cmd_count;

  int pass_cnt = 0;
  int total    = 0;
  int we_cnt   = 0;

  alu_ram_sequencer #(.SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_imm(cmd_imm),
    .cmd_dst(cmd_dst), .cmd_src0(cmd_src0), .cmd_src1(cmd_src1), .cmd_sel(cmd_sel),
    .data(data), .write_enable(write_enable), .addr_write(addr_write),
    .addr0(addr0), .addr1(addr1), .select(select),
    .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .cmd_count(cmd_count)
  );

  always #5 clock = ~clock;

  // ALU: {carry, result}. Subtract reports borrow as carry.
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    case (s)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {a < b, 8'(a - b)};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {a, 1'b0};
      default: return {1'b0, a};
    endcase
  endfunction

  // TOP stand-in
  logic [7:0] rf [16];
  logic [8:0] alu_out;
  initial for (int i = 0; i < 16; i++) rf[i] = 8'd0;
  always @(posedge clock) begin
    if (write_enable) begin
      rf[addr_write] <= data;
      we_cnt++;
    end
  end
  assign alu_out    = alu_f(rf[addr0], rf[addr1], select);
  assign result     = alu_out[7:0];
  assign carry_flag = alu_out[8];
  assign zero_flag  = (alu_out[7:0] == 8'd0);

  logic [7:0] model_rf [16];
  initial for (int i = 0; i < 16; i++) model_rf[i] = 8'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] imm, input logic [3:0] dst,
                         input logic [3:0] s0, input logic [3:0] s1, input logic [2:0] sel,
                         input logic [7:0] e_res, input logic e_z, input logic e_c, input logic e_err,
                         input int e_lat, input int e_wr, input int stall, input string name);
    int n, w0;
    logic [15:0] c0;
    logic [10:0] snap;
    logic ok;
    @(negedge clock);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    chk({name, "_ready"}, cmd_ready, 1'b1);
    c0 = cmd_count;
    w0 = we_cnt;
    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm; cmd_dst = dst;
    cmd_src0 = s0; cmd_src1 = s1; cmd_sel = sel;
    rsp_ready = (stall == 0);
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 64) begin @(negedge clock); n++; end
    chk({name, "_latency"}, n, e_lat);
    chk({name, "_rsp"}, {rsp_result, rsp_zero, rsp_carry, rsp_err}, {e_res, e_z, e_c, e_err});
    if (stall > 0) begin
      snap = {rsp_result, rsp_zero, rsp_carry, rsp_err};
      ok = 1'b1;
      repeat (stall) begin
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_imm = 8'hA5; cmd_dst = 4'd15;
        @(negedge clock);
        if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 ||
            {rsp_result, rsp_zero, rsp_carry, rsp_err} !== snap) ok = 1'b0;
      end
      chk({name, "_stall_stable"}, ok, 1'b1);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(negedge clock);
    chk({name, "_done"}, {rsp_valid, cmd_ready, cmd_count}, {1'b0, 1'b1, 16'(c0 + 16'd1)});
    chk({name, "_writes"}, we_cnt - w0, e_wr);
    if (e_wr != 0) model_rf[dst] = e_res;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) if (rf[i] !== model_rf[i]) ok = 1'b0;
    chk({name, "_regfile"}, ok, 1'b1);
  endtask

  // Expected values from the shadow register array.
  task automatic run_ref(input logic [1:0] op, input logic [7:0] imm, input logic [3:0] dst,
                         input logic [3:0] s0, input logic [3:0] s1, input logic [2:0] sel,
                         input int stall, input string name);
    logic [8:0] r;
    r = alu_f(model_rf[s0], model_rf[s1], sel);
    case (op)
      2'd0: run_cmd(op, imm, dst, s0, s1, sel, imm, imm == 8'd0, 1'b0, 1'b0, 2, 1, stall, name);
      2'd1: run_cmd(op, imm, dst, s0, s1, sel, r[7:0], r[7:0] == 8'd0, r[8], 1'b0, 1 + S, 0, stall, name);
      2'd2: run_cmd(op, imm, dst, s0, s1, sel, r[7:0], r[7:0] == 8'd0, r[8], 1'b0, 2 + S, 1, stall, name);
      default: run_cmd(op, imm, dst, s0, s1, sel, 8'd0, 1'b0, 1'b0, 1'b1, 1, 0, stall, name);
    endcase
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] imm;
    logic [3:0] dst, s0, s1;
    logic [2:0] sel;
    logic [7:0] res;
    logic       z, c, err;
    int         lat, wr;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int n, w0;
    logic [8:0] e;
    logic ok;

    //          op    imm     dst   s0    s1    sel   res     z     c     err  lat    wr
    tbl[0]  = '{2'd0, 8'd100, 4'd1, 4'd0, 4'd0, 3'd0, 8'd100, 1'b0, 1'b0, 1'b0, 2,     1};
    tbl[1]  = '{2'd0, 8'd50,  4'd2, 4'd0, 4'd0, 3'd0, 8'd50,  1'b0, 1'b0, 1'b0, 2,     1};
    tbl[2]  = '{2'd0, 8'd150, 4'd3, 4'd0, 4'd0, 3'd0, 8'd150, 1'b0, 1'b0, 1'b0, 2,     1};
    tbl[3]  = '{2'd0, 8'd250, 4'd4, 4'd0, 4'd0, 3'd0, 8'd250, 1'b0, 1'b0, 1'b0, 2,     1};
    tbl[4]  = '{2'd1, 8'd0,   4'd0, 4'd4, 4'd2, 3'd0, 8'd44,  1'b0, 1'b1, 1'b0, 1 + S, 0};
    tbl[5]  = '{2'd2, 8'd0,   4'd5, 4'd4, 4'd2, 3'd1, 8'd200, 1'b0, 1'b0, 1'b0, 2 + S, 1};
    tbl[6]  = '{2'd1, 8'd0,   4'd0, 4'd5, 4'd5, 3'd1, 8'd0,   1'b1, 1'b0, 1'b0, 1 + S, 0};
    tbl[7]  = '{2'd3, 8'd77,  4'd8, 4'd1, 4'd2, 3'd0, 8'd0,   1'b0, 1'b0, 1'b1, 1,     0};
    tbl[8]  = '{2'd0, 8'd0,   4'd7, 4'd0, 4'd0, 3'd0, 8'd0,   1'b1, 1'b0, 1'b0, 2,     1};
    // write-back onto its own operand: old r3 (150) + r1 (100)
    tbl[9]  = '{2'd2, 8'd0,   4'd3, 4'd3, 4'd1, 3'd0, 8'd250, 1'b0, 1'b0, 1'b0, 2 + S, 1};
    tbl[10] = '{2'd1, 8'd0,   4'd0, 4'd3, 4'd3, 3'd2, 8'd250, 1'b0, 1'b0, 1'b0, 1 + S, 0};

    reset = 1'b1; rsp_ready = 1'b1; cmd_valid = 1'b0;
    cmd_op = '0; cmd_imm = '0; cmd_dst = '0; cmd_src0 = '0; cmd_src1 = '0; cmd_sel = '0;
    @(posedge clock);
    @(negedge clock);
    chk("reset_outputs",
        {data, write_enable, addr_write, addr0, addr1, select, rsp_valid, rsp_result,
         rsp_zero, rsp_carry, rsp_err, cmd_count, cmd_ready}, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", cmd_ready, 1'b1);

    for (int i = 0; i < 11; i++)
      run_cmd(tbl[i].op, tbl[i].imm, tbl[i].dst, tbl[i].s0, tbl[i].s1, tbl[i].sel,
              tbl[i].res, tbl[i].z, tbl[i].c, tbl[i].err, tbl[i].lat, tbl[i].wr, 0,
              $sformatf("vec%0d", i));
    chk("count_after_table", cmd_count, 16'd11);

    run_ref(2'd1, 8'd0, 4'd0, 4'd4, 4'd2, 3'd0, 20, "stall20");

    for (int i = 0; i < 40; i++)
      run_ref(2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom), 4'($urandom),
              4'($urandom), 3'($urandom), $urandom_range(0, 3), $sformatf("rnd%0d", i));
    chk("count_after_random", cmd_count, 16'd52);

    // Reset landing on the write-back cycle of EXEC_WB into r6.
    e = alu_f(model_rf[1], model_rf[2], 3'd0);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_dst = 4'd6; cmd_src0 = 4'd1; cmd_src1 = 4'd2; cmd_sel = 3'd0;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    n = 1;
    while (write_enable !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    chk("wb_cycle", n, S + 1);
    chk("wb_drive", {addr_write, data}, {4'd6, e[7:0]});
    w0 = we_cnt;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_wb_outputs", {write_enable, rsp_valid, cmd_ready, cmd_count}, 19'd0);
    model_rf[6] = e[7:0];
    chk("rst_wb_regfile", rf[6], e[7:0]);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_wb_ready", cmd_ready, 1'b1);
    ok = 1'b1;
    repeat (4) begin
      if (rsp_valid !== 1'b0) ok = 1'b0;
      @(negedge clock);
    end
    chk("rst_wb_no_rsp", {ok, 32'(we_cnt - w0)}, {1'b1, 32'd1});

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
